lut_eval_seq: RTL and testbench
===============================

// Module: lut_eval_seq
// PURPOSE
//   Registered, parametrised N-input Boolean function evaluator; the function is a runtime-loadable truth table.
//   Two modes: single evaluation through a valid/ready handshake, or an automatic sweep of all 2**N_IN minterms.
//   A sweep streams every result and counts the minterms that evaluate to 1.
//   Lab-level block; used to exhaustively exercise and check SOP/POS equations such as Y=(A*B*C')+(B+C)'.
// PARAMETERS
//   N_IN     3      number of function inputs, legal range 1..6; in_vec[N_IN-1] is A (MSB)
//   TT_RST   8'h51  truth table loaded at reset; width 2**N_IN; bit i = f(i); 8'h51 = minterms 0,4,6
// PORTS
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   tt_wr      in   1          load tt_din into the truth table (honoured only while IDLE)
//   tt_din     in   2**N_IN    new truth table
//   in_valid   in   1          single-evaluation request
//   in_ready   out  1          = (state==IDLE) && !start
//   in_vec     in   N_IN       input combination to evaluate
//   start      in   1          begin a full sweep (honoured only while IDLE)
//   out_valid  out  1          out_idx/out_y valid this cycle; no downstream stall
//   out_idx    out  N_IN       input combination that produced out_y
//   out_y      out  1          function value tt[out_idx]
//   busy       out  1          = (state!=IDLE)
//   done       out  1          = (state==DONE); one-cycle pulse
//   ones_cnt   out  N_IN+1     ones counted in the current/last sweep (holds up to 2**N_IN)
//   ref_tt     in   2**N_IN    [LUT_EVAL_CMP_EN] golden truth table
//   mismatch   out  1          [LUT_EVAL_CMP_EN] sticky: sweep found tt != ref_tt
//   first_bad  out  N_IN       [LUT_EVAL_CMP_EN] lowest mismatching index of the last sweep
// BEHAVIOUR
//   Reset: state=IDLE, tt=TT_RST, cnt=0, all outputs 0 (in_ready=1 once rst_n deasserts). Reset mid-sweep aborts it; no done pulse.
//   FSM: IDLE -start-> SWEEP; SWEEP -(cnt==2**N_IN-1)-> DONE; DONE -> IDLE (always one cycle).
//   Single evaluation: handshake at edge t -> out_valid=1, out_idx=in_vec, out_y=tt[in_vec] during cycle t+1; latency 1, throughput 1/cycle.
//   Sweep: start sampled in IDLE at edge t -> SWEEP, cnt=0, ones_cnt=0, mismatch/first_bad cleared.
//     Each SWEEP edge: out regs<=eval(cnt), ones_cnt+=tt[cnt], cnt++.
//     Results idx 0..2**N_IN-1 are valid in cycles t+2 .. t+2**N_IN+1.
//     done is high together with the last result; ones_cnt is final while done is high and holds until the next start.
//   Priority in IDLE: start beats in_valid (in_ready low); the request is not consumed.
//   start or in_valid while busy: ignored. cnt wrap: cnt stops at max; there is no wrap into a second pass.
//   tt_wr: ignored while busy; in IDLE the new table applies from the next cycle.
//     An evaluation handshaken in the same cycle as tt_wr uses the old table.
//   out_valid is low in every cycle without a new result; out_idx/out_y hold their last values.
// CONFIGURATION
//   LUT_EVAL_CMP_EN defined: ref_tt/mismatch/first_bad exist.
//     Each swept index with tt[i]!=ref_tt[i] sets mismatch.
//     first_bad captures the first such i; the first clear of both happens at start.
//   Not defined: none of these ports or the compare logic exist; all other behaviour is identical.
// STRUCTURE
//   lut_eval_pkg: state enum {IDLE,SWEEP,DONE}, TT_RST default constant, N_IN limit constant.
//   Sub-module lut_eval_core: combinational y = tt[idx] (+ cmp bit), instantiated once and shared by both modes.
// TESTING
//   Reset, TT_RST=8'h51, start -> out_y sequence for idx0..7 = 1,0,0,0,1,0,1,0; ones_cnt=3; done with idx7; busy for 9 cycles.
//   Single evaluation, in_vec=3'b110 -> out_y=1 next cycle; in_vec=3'b011 -> 0; back-to-back requests yield 1 result/cycle.
//   tt_wr with tt_din=8'h31 (Y=AB'C+(B+C)'), then sweep -> ones at idx 0,4,5; ones_cnt=3.
//     tt_wr issued mid-sweep -> ignored.
//   start and in_valid in the same IDLE cycle -> sweep starts, in_ready=0, no single result.
//     in_valid during a sweep -> no extra out_valid.
//   rst_n pulsed low at sweep idx 4 -> all outputs 0 immediately, tt=8'h51, no done.
//     A fresh start afterwards sweeps normally.
//   [LUT_EVAL_CMP_EN] tt=8'h51, ref_tt=8'h31, sweep -> mismatch=1, first_bad=5.
//     tt=ref_tt=8'h31 -> mismatch=0.

Source files
------------

// File: rtl/lut_eval_pkg.sv
// Shared types and constants for the LUT evaluator.
// Optional feature macro: LUT_EVAL_CMP_EN (golden-table compare).
package lut_eval_pkg;

  // Widest supported function; the truth table is 2**N_IN bits wide.
  localparam int unsigned N_IN_MAX = 6;

  // Truth table loaded at reset. Only the low 2**N_IN bits are used.
  // 8'h51 selects minterms 0, 4 and 6.
  localparam logic [63:0] TT_RST_DEF = 64'h0000_0000_0000_0051;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/lut_eval_core.sv
// Combinational truth-table lookup shared by single evaluation and sweep.
// Optional feature macro: LUT_EVAL_CMP_EN adds a per-index compare bit.
module lut_eval_core #(
  parameter int unsigned N_IN = 3
) (
  input  logic [(2**N_IN)-1:0] tt_i,
`ifdef LUT_EVAL_CMP_EN
  input  logic [(2**N_IN)-1:0] ref_i,
  output logic                 bad_o,
`endif
  input  logic [N_IN-1:0]      idx_i,
  output logic                 y_o
);

  assign y_o = tt_i[idx_i];

`ifdef LUT_EVAL_CMP_EN
  // The loaded function disagrees with the golden table at this index.
  assign bad_o = tt_i[idx_i] ^ ref_i[idx_i];
`endif

endmodule

// File: rtl/lut_eval_seq.sv
// Registered N-input Boolean function evaluator with a loadable truth table.
// Single evaluations use a valid/ready handshake; a sweep walks all minterms
// and counts the ones. Optional feature macro: LUT_EVAL_CMP_EN.
module lut_eval_seq
  import lut_eval_pkg::*;
#(
  parameter int unsigned N_IN   = 3,          // legal range 1..N_IN_MAX
  parameter logic [63:0] TT_RST = TT_RST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tt_wr,
  input  logic [(2**N_IN)-1:0] tt_din,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 start,
  output logic                 out_valid,
  output logic [N_IN-1:0]      out_idx,
  output logic                 out_y,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        ones_cnt
`ifdef LUT_EVAL_CMP_EN
  ,
  input  logic [(2**N_IN)-1:0] ref_tt,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_bad
`endif
);

  localparam int unsigned          TT_W    = 2**N_IN;
  localparam logic [TT_W-1:0]      TT_INIT = TT_RST[TT_W-1:0];
  localparam logic [N_IN-1:0]      IDX_MAX = {N_IN{1'b1}};

  state_e            state_q, state_d;
  logic [N_IN-1:0]   cnt_q, cnt_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic              out_valid_q, out_valid_d;
  logic [N_IN-1:0]   out_idx_q, out_idx_d;
  logic              out_y_q, out_y_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic [N_IN-1:0]   eval_idx_s;
  logic              y_s;
`ifdef LUT_EVAL_CMP_EN
  logic              bad_s;
  logic              mismatch_q, mismatch_d;
  logic [N_IN-1:0]   first_bad_q, first_bad_d;
`endif

  // During a sweep the counter drives the lookup, otherwise the request does.
  assign eval_idx_s = (state_q == SWEEP) ? cnt_q : in_vec;

  lut_eval_core #(
    .N_IN (N_IN)
  ) u_core (
    .tt_i  (tt_q),
`ifdef LUT_EVAL_CMP_EN
    .ref_i (ref_tt),
    .bad_o (bad_s),
`endif
    .idx_i (eval_idx_s),
    .y_o   (y_s)
  );

  // Next-state and datapath update for the IDLE/SWEEP/DONE controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tt_d        = tt_q;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    out_y_d     = out_y_q;
    ones_d      = ones_q;
`ifdef LUT_EVAL_CMP_EN
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
`endif
    case (state_q)
      IDLE: begin
        // Lookup reads tt_q, so a same-cycle evaluation sees the old table.
        if (tt_wr) begin
          tt_d = tt_din;
        end else begin
          tt_d = tt_q;
        end
        // start wins over a pending request; the request stays unconsumed.
        if (start) begin
          state_d = SWEEP;
          cnt_d   = {N_IN{1'b0}};
          ones_d  = {(N_IN+1){1'b0}};
`ifdef LUT_EVAL_CMP_EN
          mismatch_d  = 1'b0;
          first_bad_d = {N_IN{1'b0}};
`endif
        end else if (in_valid) begin
          out_valid_d = 1'b1;
          out_idx_d   = in_vec;
          out_y_d     = y_s;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      SWEEP: begin
        out_valid_d = 1'b1;
        out_idx_d   = cnt_q;
        out_y_d     = y_s;
        ones_d      = ones_q + (N_IN+1)'(y_s);
`ifdef LUT_EVAL_CMP_EN
        // mismatch doubles as "first_bad already captured".
        if (bad_s && !mismatch_q) begin
          mismatch_d  = 1'b1;
          first_bad_d = cnt_q;
        end else begin
          mismatch_d  = mismatch_q;
          first_bad_d = first_bad_q;
        end
`endif
        // Counter parks at the last index; a sweep is exactly one pass.
        if (cnt_q == IDX_MAX) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + N_IN'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset reloads the default table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {N_IN{1'b0}};
      tt_q        <= TT_INIT;
      out_valid_q <= 1'b0;
      out_idx_q   <= {N_IN{1'b0}};
      out_y_q     <= 1'b0;
      ones_q      <= {(N_IN+1){1'b0}};
`ifdef LUT_EVAL_CMP_EN
      mismatch_q  <= 1'b0;
      first_bad_q <= {N_IN{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tt_q        <= tt_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_y_q     <= out_y_d;
      ones_q      <= ones_d;
`ifdef LUT_EVAL_CMP_EN
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !start;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_y     = out_y_q;
  assign ones_cnt  = ones_q;
`ifdef LUT_EVAL_CMP_EN
  assign mismatch  = mismatch_q;
  assign first_bad = first_bad_q;
`endif

endmodule

// File: tb/tb_lut_eval_seq.sv
// Self-checking bench for lut_eval_seq (N_IN = 3).
// Optional feature macro: LUT_EVAL_CMP_EN enables the compare-port checks.
module tb_lut_eval_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tt_wr;
  logic [7:0] tt_din;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_vec;
  logic       start;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_y;
  logic       busy;
  logic       done;
  logic [3:0] ones_cnt;
  logic [7:0] ref_tt;
`ifdef LUT_EVAL_CMP_EN
  logic       mismatch;
  logic [2:0] first_bad;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the table the DUT should hold, and the last result shown.
  logic [7:0] tt_m;
  logic [2:0] last_idx;
  logic       last_y;

  typedef struct {
    logic [7:0] tt;
    logic [2:0] vec;
    logic       y;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  lut_eval_seq #(.N_IN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tt_wr     (tt_wr),
    .tt_din    (tt_din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .start     (start),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_y     (out_y),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt)
`ifdef LUT_EVAL_CMP_EN
    ,
    .ref_tt    (ref_tt),
    .mismatch  (mismatch),
    .first_bad (first_bad)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tt(input logic [7:0] v);
    tt_wr  = 1'b1;
    tt_din = v;
    tick();
    tt_wr  = 1'b0;
    tt_m   = v;
  endtask

  // Full sweep with expectations derived from the table: one result per
  // minterm in index order, done with the last one, busy for 2**3+1 cycles.
  task automatic run_sweep(input logic [7:0] exp_tt, input bit hold_valid, input bit try_wr);
    int         busy_n;
    int         exp_ones;
    logic [7:0] diff;
    logic [2:0] fb;
    exp_ones = $countones(exp_tt);
    diff     = exp_tt ^ ref_tt;
    fb       = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (diff[k]) fb = 3'(k);
    end
    start    = 1'b1;
    in_valid = hold_valid;
    in_vec   = 3'd6;
    #1;
    chk("in_ready_at_start", {31'd0, in_ready}, 32'd0);
    tick();
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    chk("sweep_no_single_result", {31'd0, out_valid}, 32'd0);
`ifdef LUT_EVAL_CMP_EN
    chk("mismatch_cleared", {31'd0, mismatch}, 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      tt_wr  = try_wr && (i == 3);
      tt_din = ~exp_tt;
      if (hold_valid) in_vec = 3'($urandom_range(0, 7));
      tick();
      if (busy) busy_n++;
      chk("sweep_valid", {31'd0, out_valid}, 32'd1);
      chk("sweep_idx", {29'd0, out_idx}, i);
      chk("sweep_y", {31'd0, out_y}, {31'd0, exp_tt[i]});
      chk("sweep_done", {31'd0, done}, (i == 7) ? 32'd1 : 32'd0);
    end
    tt_wr    = 1'b0;
    in_valid = 1'b0;
    chk("sweep_ones", {28'd0, ones_cnt}, exp_ones);
`ifdef LUT_EVAL_CMP_EN
    chk("sweep_mismatch", {31'd0, mismatch}, (diff != 8'd0) ? 32'd1 : 32'd0);
    chk("sweep_first_bad", {29'd0, first_bad}, {29'd0, fb});
`endif
    tick();
    if (busy) busy_n++;
    chk("post_sweep_valid", {31'd0, out_valid}, 32'd0);
    chk("post_sweep_done", {31'd0, done}, 32'd0);
    chk("post_sweep_ones_hold", {28'd0, ones_cnt}, exp_ones);
    chk("post_sweep_idx_hold", {29'd0, out_idx}, 32'd7);
    chk("busy_cycles", busy_n, 32'd9);
    last_idx = 3'd7;
    last_y   = exp_tt[7];
  endtask

  initial begin
    rst_n    = 1'b0;
    tt_wr    = 1'b0;
    tt_din   = 8'h00;
    in_valid = 1'b0;
    in_vec   = 3'd0;
    start    = 1'b0;
    ref_tt   = 8'h51;
    tt_m     = 8'h51;
    last_idx = 3'd0;
    last_y   = 1'b0;

    // Reset state.
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_idx", {29'd0, out_idx}, 32'd0);
    chk("rst_out_y", {31'd0, out_y}, 32'd0);
    chk("rst_ones", {28'd0, ones_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
`ifdef LUT_EVAL_CMP_EN
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
`endif
    #10 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Sweep of the reset table 8'h51: y = 1,0,0,0,1,0,1,0, three ones.
    run_sweep(8'h51, 1'b0, 1'b0);

    // Table-driven single evaluations, expectations worked out by hand.
    tbl[0] = '{tt: 8'h51, vec: 3'b110, y: 1'b1};
    tbl[1] = '{tt: 8'h51, vec: 3'b011, y: 1'b0};
    tbl[2] = '{tt: 8'h51, vec: 3'b000, y: 1'b1};
    tbl[3] = '{tt: 8'h31, vec: 3'b101, y: 1'b1};
    tbl[4] = '{tt: 8'h31, vec: 3'b001, y: 1'b0};
    tbl[5] = '{tt: 8'h31, vec: 3'b100, y: 1'b1};
    tbl[6] = '{tt: 8'hFE, vec: 3'b000, y: 1'b0};
    tbl[7] = '{tt: 8'h80, vec: 3'b111, y: 1'b1};
    for (int i = 0; i < 8; i++) begin
      load_tt(tbl[i].tt);
      in_valid = 1'b1;
      in_vec   = tbl[i].vec;
      tick();
      in_valid = 1'b0;
      chk("tbl_valid", {31'd0, out_valid}, 32'd1);
      chk("tbl_idx", {29'd0, out_idx}, {29'd0, tbl[i].vec});
      chk("tbl_y", {31'd0, out_y}, {31'd0, tbl[i].y});
    end

    // Write and evaluate in the same cycle: the old table answers.
    load_tt(8'h51);
    tt_wr    = 1'b1;
    tt_din   = 8'hAE;
    in_valid = 1'b1;
    in_vec   = 3'd0;
    tick();
    tt_wr = 1'b0;
    tt_m  = 8'hAE;
    chk("wr_same_cycle_old_y", {31'd0, out_y}, 32'd1);
    tick();
    chk("wr_next_cycle_new_y", {31'd0, out_y}, 32'd0);

    // Back-to-back requests: one result every cycle.
    load_tt(8'h51);
    in_valid = 1'b1;
    in_vec   = 3'b110;
    tick();
    chk("b2b_0_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_0_y", {31'd0, out_y}, 32'd1);
    in_vec = 3'b011;
    tick();
    in_valid = 1'b0;
    chk("b2b_1_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_1_idx", {29'd0, out_idx}, 32'd3);
    chk("b2b_1_y", {31'd0, out_y}, 32'd0);
    tick();
    chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_y_hold", {31'd0, out_y}, 32'd0);

    // New table 8'h31, with a write attempted mid-sweep that must be ignored.
    load_tt(8'h31);
    ref_tt = 8'h31;
    run_sweep(8'h31, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_vec   = 3'd6;
    tick();
    in_valid = 1'b0;
    chk("after_ignored_wr_y", {31'd0, out_y}, 32'd0);

    // start together with in_valid, and in_valid held through the sweep.
    run_sweep(8'h31, 1'b1, 1'b0);

    // Reset pulse while the sweep shows idx 4.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_reset_idx", {29'd0, out_idx}, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_idx", {29'd0, out_idx}, 32'd0);
    chk("midrst_y", {31'd0, out_y}, 32'd0);
    chk("midrst_ones", {28'd0, ones_cnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    tt_m = 8'h51;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_done", {31'd0, done}, 32'd0);
      chk("midrst_idle", {31'd0, busy}, 32'd0);
    end
    ref_tt = 8'h51;
    run_sweep(8'h51, 1'b0, 1'b0);

    // Golden-table compare cases: 8'h51 vs 8'h31 differ first at 5.
    ref_tt = 8'h31;
    run_sweep(8'h51, 1'b0, 1'b0);
    load_tt(8'h31);
    run_sweep(8'h31, 1'b0, 1'b0);

    // Randomized IDLE traffic against the model, with periodic sweeps.
    for (int c = 0; c < 400; c++) begin
      if (c % 80 == 0) begin
        ref_tt = 8'($urandom);
        run_sweep(tt_m, 1'b0, 1'b0);
      end
      in_valid = 1'($urandom_range(0, 1));
      in_vec   = 3'($urandom_range(0, 7));
      tt_wr    = ($urandom_range(0, 7) == 0);
      tt_din   = 8'($urandom);
      if (in_valid) begin
        last_idx = in_vec;
        last_y   = tt_m[in_vec];
      end
      #1;
      chk("rnd_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (tt_wr) tt_m = tt_din;
      chk("rnd_valid", {31'd0, out_valid}, {31'd0, in_valid});
      chk("rnd_idx", {29'd0, out_idx}, {29'd0, last_idx});
      chk("rnd_y", {31'd0, out_y}, {31'd0, last_y});
    end
    tt_wr    = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
